// File: rtl/scan_pkg.sv
// Shared definitions for the scan-trigger generator: FSM encoding, default
// field widths and the guaranteed minimum SI low time.
package scan_pkg;

   localparam int CNT_W_DEF = 16;
   localparam int NUM_W_DEF = 8;
   localparam int MIN_LOW   = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2,
      ST_FIN  = 2'd3
   } scan_state_e;

endpackage

// File: rtl/scan_pulse_cnt.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
module scan_pulse_cnt #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic         en_i,
   input  logic [W-1:0] val_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = val_i;
      else if (en_i && (cnt_q != '0))
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/scan_trig_gen.sv
// Scan-trigger burst generator: emits pulse_num SI pulses of a given width and
// period, and tracks the toggle state the far-end edge detector holds.
module scan_trig_gen
   import scan_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int NUM_W = NUM_W_DEF
) (
   input  logic             clk24m,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [NUM_W-1:0] pulse_num,
   input  logic [CNT_W-1:0] pulse_width,
   input  logic [CNT_W-1:0] period,
   output logic             si,
   output logic             busy,
   output logic             done,
   output logic             cs_mirror
);

   scan_state_e state_q, state_d;

   logic [CNT_W-1:0] width_q, period_q;
   logic             lat_en;

   logic si_q, si_d;
   logic busy_q, busy_d;
   logic done_q, done_d;
   logic cs_q, cs_d;

   logic             ph_load, ph_en, ph_zero;
   logic [CNT_W-1:0] ph_val;
   logic             pc_load, pc_en, pc_zero;

   // One extra bit: width + minimum low time can exceed the field range.
   logic [CNT_W:0] we_in, we_lat, pe_min, pe_lat, low_lat;

   function automatic logic [CNT_W:0] eff_width(input logic [CNT_W-1:0] w);
      return (w == '0) ? {{CNT_W{1'b0}}, 1'b1} : {1'b0, w};
   endfunction

   always_comb begin
      we_in   = eff_width(pulse_width);
      we_lat  = eff_width(width_q);
      pe_min  = we_lat + (CNT_W+1)'(MIN_LOW);
      pe_lat  = ({1'b0, period_q} < pe_min) ? pe_min : {1'b0, period_q};
      low_lat = pe_lat - we_lat;
   end

   // Phase counter: remaining cycles of the current high or low phase.
   scan_pulse_cnt #(.W(CNT_W)) u_phase_cnt (
      .clk_i  (clk24m),
      .rst_i  (rst),
      .load_i (ph_load),
      .en_i   (ph_en),
      .val_i  (ph_val),
      .zero_o (ph_zero)
   );

   // Pulse counter: loaded with pulse_num on start, decremented per pulse.
   scan_pulse_cnt #(.W(NUM_W)) u_pulse_cnt (
      .clk_i  (clk24m),
      .rst_i  (rst),
      .load_i (pc_load),
      .en_i   (pc_en),
      .val_i  (pulse_num),
      .zero_o (pc_zero)
   );

   always_comb begin
      state_d = state_q;
      si_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      cs_d    = cs_q;
      lat_en  = 1'b0;
      ph_load = 1'b0;
      ph_en   = 1'b0;
      ph_val  = '0;
      pc_load = 1'b0;
      pc_en   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               lat_en  = 1'b1;
               pc_load = 1'b1;
               if (pulse_num == '0) begin
                  state_d = ST_FIN;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_HIGH;
                  si_d    = 1'b1;
                  busy_d  = 1'b1;
                  cs_d    = ~cs_q;
                  ph_load = 1'b1;
                  ph_val  = CNT_W'(we_in - 1'b1);
               end
            end
         end

         ST_HIGH: begin
            busy_d = 1'b1;
            if (stop) begin
               state_d = ST_FIN;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else if (ph_zero) begin
               state_d = ST_LOW;
               ph_load = 1'b1;
               ph_val  = CNT_W'(low_lat - 1'b1);
               pc_en   = 1'b1;
            end else begin
               si_d  = 1'b1;
               ph_en = 1'b1;
            end
         end

         ST_LOW: begin
            busy_d = 1'b1;
            if (stop) begin
               state_d = ST_FIN;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else if (ph_zero) begin
               if (pc_zero) begin
                  state_d = ST_FIN;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_HIGH;
                  si_d    = 1'b1;
                  cs_d    = ~cs_q;
                  ph_load = 1'b1;
                  ph_val  = CNT_W'(we_lat - 1'b1);
               end
            end else begin
               ph_en = 1'b1;
            end
         end

         ST_FIN: begin
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk24m) begin
      if (rst) begin
         state_q <= ST_IDLE;
         si_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         si_q    <= si_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cs_q    <= cs_d;
      end
   end

   // Burst parameters are frozen until the FSM returns to idle.
   always_ff @(posedge clk24m) begin
      if (rst) begin
         width_q  <= '0;
         period_q <= '0;
      end else if (lat_en) begin
         width_q  <= pulse_width;
         period_q <= period;
      end
   end

   assign si        = si_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign cs_mirror = cs_q;

endmodule
